// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multipliers built from xtime, plus the
// common state types used by the round datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_RUN,
        MC_DONE
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Only the MixColumns/InvMixColumns coefficients are supported; others give 0.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            4'h1:    res = a;
            4'h2:    res = x2;
            4'h3:    res = x2 ^ a;
            4'h9:    res = x8 ^ a;
            4'hB:    res = x8 ^ x2 ^ a;
            4'hD:    res = x8 ^ x4 ^ a;
            4'hE:    res = x8 ^ x4 ^ x2;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mix_col_word.sv
// Combinational MixColumns/InvMixColumns of one 32-bit column; row 0 is the
// top byte. With INV_EN = 0 the inverse coefficients are never selected.
module mix_col_word
    import aes_pkg::*;
#(
    parameter int unsigned INV_EN = 1
) (
    input  logic [31:0] i_col,
    input  logic        i_inv,
    output logic [31:0] o_col
);

    logic       w_inv;
    logic [7:0] w_a [4];
    logic [3:0] w_k [4];

    assign w_inv = (INV_EN != 0) && i_inv;

    for (genvar r = 0; r < 4; r++) begin : g_byte
        assign w_a[r] = i_col[31 - 8*r -: 8];
    end

    // First row of each circulant matrix; later rows rotate it right by one.
    assign w_k[0] = w_inv ? 4'hE : 4'h2;
    assign w_k[1] = w_inv ? 4'hB : 4'h3;
    assign w_k[2] = w_inv ? 4'hD : 4'h1;
    assign w_k[3] = w_inv ? 4'h9 : 4'h1;

    always_comb begin
        o_col = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                o_col[31 - 8*r -: 8] = o_col[31 - 8*r -: 8]
                                     ^ gf_mul_const(w_a[2'(r + j)], w_k[j]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns/InvMixColumns engine: a 128-bit state is transformed
// in place, COLS_PER_CYC columns per cycle, behind valid/ready handshakes.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYC = 1,
    parameter int unsigned INV_EN       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYC must be 1, 2 or 4");
    end

    localparam int unsigned NUM_GRP  = 4 / COLS_PER_CYC;
    localparam logic [1:0]  LAST_GRP = 2'(NUM_GRP - 1);

    mc_state_e  r_state;
    mc_state_e  w_state_nxt;
    aes_state_t r_data;
    aes_state_t r_out;
    logic       r_mode;
    logic [1:0] r_col_cnt;

    logic       w_load;
    logic       w_last;
    aes_state_t w_data_nxt;
    logic [1:0] w_idx     [COLS_PER_CYC];
    aes_col_t   w_col_in  [COLS_PER_CYC];
    aes_col_t   w_col_out [COLS_PER_CYC];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            MC_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = MC_RUN;
                end
            end
            MC_RUN: begin
                busy = 1'b1;
                if (r_col_cnt == LAST_GRP) begin
                    w_last      = 1'b1;
                    w_state_nxt = MC_DONE;
                end
            end
            MC_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = MC_RUN;
                    end else begin
                        w_state_nxt = MC_IDLE;
                    end
                end
            end
            default: w_state_nxt = MC_IDLE;
        endcase
    end

    // Group col_cnt covers columns col_cnt*COLS_PER_CYC .. +COLS_PER_CYC-1.
    for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_col
        assign w_idx[g]    = 2'(32'(r_col_cnt) * COLS_PER_CYC + g);
        assign w_col_in[g] = r_data[{w_idx[g], 5'd0} +: 32];

        mix_col_word #(
            .INV_EN (INV_EN)
        ) u_mix_col_word (
            .i_col (w_col_in[g]),
            .i_inv (r_mode),
            .o_col (w_col_out[g])
        );
    end

    always_comb begin
        w_data_nxt = r_data;
        for (int g = 0; g < COLS_PER_CYC; g++) begin
            w_data_nxt[{w_idx[g], 5'd0} +: 32] = w_col_out[g];
        end
    end

    // NOTE: the working state has no reset; it is always loaded from in_data before it is read.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_data <= in_data;
        end else if (busy) begin
            r_data <= w_data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= '0;
            r_mode    <= 1'b0;
            r_col_cnt <= 2'd0;
        end else begin
            if (w_load) begin
                r_mode    <= (INV_EN != 0) && in_inv;
                r_col_cnt <= 2'd0;
            end else if (busy) begin
                r_col_cnt <= w_last ? 2'd0 : r_col_cnt + 2'd1;
            end
            // The result register only changes when a new result completes.
            if (w_last) begin
                r_out <= w_data_nxt;
            end
        end
    end

    assign out_data = r_out;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter across all COLS_PER_CYC / INV_EN builds.
module tb_mix_columns_iter;

    localparam int ND = 6;
    localparam int unsigned CPC   [ND] = '{1, 2, 4, 1, 2, 4};
    localparam int unsigned INVEN [ND] = '{1, 1, 1, 0, 0, 0};
    localparam int NSWEEP = 250;

    localparam logic [127:0] V0 = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    localparam logic [127:0] R0 = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
    localparam logic [127:0] V1 = {4{32'hd4d4d4d5}};
    localparam logic [127:0] R1 = {4{32'hd5d5d7d6}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic         in_inv    [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic         busy      [ND];
    logic [127:0] in_data   [ND];
    logic [127:0] out_data  [ND];

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        mix_columns_iter #(
            .COLS_PER_CYC (CPC[gi]),
            .INV_EN       (INVEN[gi])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi]),
            .in_inv    (in_inv[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (out_data[gi]),
            .busy      (busy[gi])
        );
    end

    // Reference model: generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   k [4];
        logic [7:0]   acc;
        if (inv) begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[32*c + 31 - 8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[(r + j) % 4], k[j]);
                o[32*c + 31 - 8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    // Drives one cycle of inputs on the falling edge and lets combinational outputs settle.
    task automatic set_in(input int d, input logic v, input logic [127:0] data,
                          input logic inv, input logic rdy);
        @(negedge clk);
        in_valid[d]  = v;
        in_data[d]   = data;
        in_inv[d]    = inv;
        out_ready[d] = rdy;
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_inv[d]    = 1'b0;
            out_ready[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            n_tests++;
            if (out_valid[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, out_valid[d]);
            end
            n_tests++;
            if (busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]);
            end
            n_tests++;
            if (in_ready[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, in_ready[d]);
            end
            n_tests++;
            if (out_data[d] !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_out_data[%0d]: got %h expected 0", d, out_data[d]);
            end
        end
    endtask

    typedef struct {
        int           d;
        logic [127:0] din;
        logic         inv;
        logic [127:0] dout;
        int           lat;
    } vec_t;

    task automatic test_vectors();
        vec_t         tbl [$];
        logic [127:0] exp;
        int           lat;
        bit           got;
        tbl.push_back('{0, V0, 1'b0, R0, 4});
        tbl.push_back('{1, R0, 1'b1, V0, 2});
        tbl.push_back('{1, V1, 1'b0, R1, 2});
        tbl.push_back('{1, R1, 1'b1, V1, 2});
        tbl.push_back('{2, V0, 1'b0, R0, 1});
        tbl.push_back('{2, R0, 1'b1, V0, 1});
        tbl.push_back('{3, V0, 1'b1, R0, 4});
        tbl.push_back('{4, V1, 1'b1, R1, 2});
        foreach (tbl[t]) begin
            set_in(tbl[t].d, 1'b1, tbl[t].din, tbl[t].inv, 1'b1);
            n_tests++;
            if (in_ready[tbl[t].d] !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_in_ready: got %b expected 1", t, in_ready[tbl[t].d]);
            end
            exp_q.push_back(tbl[t].dout);
            got = 1'b0;
            lat = -1;
            for (int i = 1; i <= 10 && !got; i++) begin
                // Scrambled inputs after acceptance must not disturb the operation.
                set_in(tbl[t].d, 1'b0, ~tbl[t].din, ~tbl[t].inv, 1'b1);
                if (out_valid[tbl[t].d] === 1'b1) begin
                    got = 1'b1;
                    lat = i - 1;
                end
            end
            n_tests++;
            if (lat != tbl[t].lat) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d expected %0d", t, lat, tbl[t].lat);
            end
            if (got) begin
                exp = exp_q.pop_front();
                n_tests++;
                if (out_data[tbl[t].d] !== exp) begin
                    n_fail++;
                    $display("FAIL vec%0d_data: got %h expected %h", t, out_data[tbl[t].d], exp);
                end
            end else begin
                exp_q.delete();
            end
            set_in(tbl[t].d, 1'b0, '0, 1'b0, 1'b1);
            n_tests++;
            if (out_valid[tbl[t].d] !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_release: out_valid got %b expected 0", t, out_valid[tbl[t].d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [127:0] exp;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom};
        exp_q.delete();
        set_in(2, 1'b1, a, 1'b0, 1'b0);
        exp_q.push_back(ref_mix(a, 1'b0));
        set_in(2, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if (busy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy: got %b expected 1", busy[2]);
        end
        for (int i = 0; i < 5; i++) begin
            set_in(2, 1'b1, b, 1'b1, 1'b0);
            n_tests++;
            if (out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0 || out_data[2] !== exp_q[0]) begin
                n_fail++;
                $display("FAIL b2b_stall%0d: valid %b ready %b data %h expected 1 0 %h",
                         i, out_valid[2], in_ready[2], out_data[2], exp_q[0]);
            end
        end
        set_in(2, 1'b1, b, 1'b1, 1'b1);
        n_tests++;
        if (in_ready[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: in_ready got %b expected 1", in_ready[2]);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (out_data[2] !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: got %h expected %h", out_data[2], exp);
        end
        exp_q.push_back(ref_mix(b, 1'b1));
        set_in(2, 1'b1, c, 1'b0, 1'b1);
        n_tests++;
        if (out_valid[2] !== 1'b0 || busy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_run: valid %b busy %b expected 0 1", out_valid[2], busy[2]);
        end
        set_in(2, 1'b1, c, 1'b0, 1'b1);
        n_tests++;
        if (out_valid[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_valid: got %b expected 1", out_valid[2]);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (out_data[2] !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: got %h expected %h", out_data[2], exp);
        end
        exp_q.push_back(ref_mix(c, 1'b0));
        set_in(2, 1'b0, '0, 1'b0, 1'b1);
        set_in(2, 1'b0, '0, 1'b0, 1'b1);
        exp = exp_q.pop_front();
        n_tests++;
        if (out_valid[2] !== 1'b1 || out_data[2] !== exp) begin
            n_fail++;
            $display("FAIL b2b_third: valid %b data %h expected 1 %h", out_valid[2], out_data[2], exp);
        end
        set_in(2, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if (out_valid[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: out_valid got %b expected 0", out_valid[2]);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        set_in(0, 1'b1, V0, 1'b0, 1'b1);
        set_in(0, 1'b0, '0, 1'b0, 1'b1);
        set_in(0, 1'b0, '0, 1'b0, 1'b1);
        // Column counter is 1 here; reset lands on the next edge.
        rst = 1'b1;
        set_in(0, 1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        n_tests++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ctrl: valid %b busy %b ready %b expected 0 0 1",
                     out_valid[0], busy[0], in_ready[0]);
        end
        n_tests++;
        if (out_data[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL midrst_data: got %h expected 0", out_data[0]);
        end
        seen = 1'b0;
        repeat (8) begin
            set_in(0, 1'b0, '0, 1'b0, 1'b1);
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midrst_stale: out_valid seen 1 expected 0");
        end
        exp_q.delete();
    endtask

    task automatic test_random_sweep();
        logic [127:0] data;
        logic [127:0] exp;
        logic [127:0] prev_data;
        logic         v;
        logic         rdy;
        logic         inv;
        bit           prev_stall;
        int           acc;
        int           cyc;
        for (int d = 0; d < ND; d++) begin
            exp_q.delete();
            acc = 0;
            cyc = 0;
            prev_stall = 1'b0;
            prev_data = '0;
            while ((acc < NSWEEP || exp_q.size() != 0) && cyc < 40 * NSWEEP) begin
                v    = (acc < NSWEEP) && ($urandom_range(0, 3) != 0);
                rdy  = ($urandom_range(0, 3) != 0);
                inv  = 1'($urandom_range(0, 1));
                data = {$urandom, $urandom, $urandom, $urandom};
                set_in(d, v, data, inv, rdy);
                cyc++;
                if (prev_stall) begin
                    n_tests++;
                    if (out_valid[d] !== 1'b1 || out_data[d] !== prev_data) begin
                        n_fail++;
                        $display("FAIL sweep%0d_hold: valid %b data %h expected 1 %h",
                                 d, out_valid[d], out_data[d], prev_data);
                    end
                end
                if (in_valid[d] && in_ready[d]) begin
                    exp_q.push_back(ref_mix(data, inv && (INVEN[d] != 0)));
                    acc++;
                end
                if (out_valid[d] && out_ready[d]) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sweep%0d_unexpected: got %h expected no output", d, out_data[d]);
                    end else begin
                        exp = exp_q.pop_front();
                        if (out_data[d] !== exp) begin
                            n_fail++;
                            $display("FAIL sweep%0d_data: got %h expected %h", d, out_data[d], exp);
                        end
                    end
                end
                prev_stall = out_valid[d] && !out_ready[d];
                prev_data  = out_data[d];
            end
            n_tests++;
            if (acc < NSWEEP || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL sweep%0d_timeout: accepted %0d pending %0d expected %0d and 0",
                         d, acc, exp_q.size(), NSWEEP);
            end
            set_in(d, 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_run();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
